iecdrv_sd_arb: RTL and testbench
================================

IECDRV_SD_ARB -- requirements
Module: iecdrv_sd_arb

Interface
REQ-001 Parameter NDR, default 2, number of drive request ports; legal range 1..4.
REQ-002 Port clk_sys  in  1  sole clock; all logic rising-edge.
REQ-003 Port reset  in  1  synchronous, active-high reset.
REQ-004 Port drv_lba[NDR]  in  32  per-drive sector LBA.
REQ-005 Port drv_blk_cnt[NDR]  in  6  per-drive block count minus one.
REQ-006 Port drv_rd  in  NDR  per-drive read request, level.
REQ-007 Port drv_wr  in  NDR  per-drive write request, level.
REQ-008 Port drv_ack  out  NDR  per-drive acknowledge; at most one bit set.
REQ-009 Port drv_buff_din[NDR]  in  8  per-drive write data toward SD.
REQ-010 Port sd_lba  out  32  granted LBA.
REQ-011 Port sd_blk_cnt  out  6  granted block count.
REQ-012 Port sd_rd  out  1  shared read request.
REQ-013 Port sd_wr  out  1  shared write request.
REQ-014 Port sd_ack  in  1  shared acknowledge from the host SD bridge.
REQ-015 Port sd_buff_din  out  8  write data of the granted drive.
REQ-016 Port busy  out  1  high in any state other than IDLE.
REQ-017 Port grant_idx  out  2  index of the current or last granted drive.

Function
REQ-018 FSM states: IDLE, REQ, XFER, RELEASE.
REQ-019 IDLE: if any drive has drv_rd|drv_wr set, select the first requester searching round-robin from rr_ptr upward (wrapping at NDR), latch grant_idx, LBA, blk_cnt and direction, and go to REQ next cycle.
REQ-020 Direction: if the granted drive asserts rd and wr together, write wins; the latched direction is held until IDLE.
REQ-021 REQ: sd_rd or sd_wr is registered high, starting the first REQ cycle (1 clock after the request is sampled in IDLE); sd_lba and sd_blk_cnt hold the latched values.
REQ-022 REQ and sd_ack sampled high: next state XFER; sd_rd and sd_wr low; drv_ack[grant_idx] high.
REQ-023 REQ and the granted drive drops both rd and wr before sd_ack: abort to IDLE; sd_rd and sd_wr low; no drv_ack pulse; rr_ptr unchanged.
REQ-024 XFER: drv_ack[grant_idx] stays high while sd_ack is high; on sd_ack sampled low, go to RELEASE with drv_ack low.
REQ-025 RELEASE: one cycle; rr_ptr = (grant_idx+1) mod NDR; then IDLE.
REQ-026 Fairness: a drive that requests continuously is not granted twice in a row while another drive is requesting.
REQ-027 sd_buff_din = drv_buff_din[grant_idx] combinationally in every state; sd_buff_addr, sd_buff_dout and sd_buff_wr are not routed through this block.
REQ-028 New requests and changes on non-granted drives are ignored outside IDLE.
REQ-029 sd_ack high while in IDLE is ignored.
REQ-030 NDR=1: rr_ptr stays 0 and grant_idx is always 0.

Reset
REQ-031 On reset: state IDLE, rr_ptr 0, grant_idx 0, sd_rd 0, sd_wr 0, drv_ack 0, sd_lba 0, sd_blk_cnt 0, busy 0.
REQ-032 Reset asserted in any state, including mid-transfer, takes effect on the next edge; sd_ack is then ignored until the FSM is back in IDLE.

Structure
REQ-033 The FSM state enum and the NDR clamp constant (1..4) live in the shared iecdrv package.
REQ-034 A single sub-module, iecdrv_rr_pick, is natural: combinational round-robin first-set finder (request vector, pointer -> index, valid).
REQ-035 All outputs except sd_buff_din are registered.

Verification
REQ-036 Drive 1 sets rd, lba=0x123: sd_rd high 1 cycle later with sd_lba=0x123; sd_ack high 5 cycles -> drv_ack[1] high 5 cycles, then RELEASE, IDLE, rr_ptr=0.
REQ-037 Drives 0 and 1 request in the same cycle from reset: drive 0 served first, drive 1 second, no idle gap beyond RELEASE+IDLE.
REQ-038 Drive 0 rd held continuously, drive 1 wr pending: grants alternate 0,1,0.
REQ-039 Drive 0 drops rd in REQ before sd_ack: sd_rd falls, no drv_ack, busy 0 next cycle.
REQ-040 Reset asserted during XFER: next cycle all outputs at reset values; a late sd_ack pulse causes no drv_ack.
REQ-041 Drive 1 rd and wr both high: sd_wr high, sd_rd 0; sd_buff_din follows drv_buff_din[1] (0xA5).

Source files
------------

// File: rtl/iecdrv_pkg.sv
// Shared types and constants for the IEC drive SD arbiter.
// Holds the arbiter FSM encoding and the legal range for the drive-port count.
package iecdrv_pkg;

  localparam int NDR_MIN = 1;
  localparam int NDR_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_XFER    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  // Forces any requested port count into the range the 2-bit grant index can address.
  function automatic int iecdrv_clamp_ndr(input int n);
    if (n < NDR_MIN) return NDR_MIN;
    if (n > NDR_MAX) return NDR_MAX;
    return n;
  endfunction

endpackage

// File: rtl/iecdrv_rr_pick.sv
// Combinational round-robin finder: first set request at or after ptr, wrapping at N.
module iecdrv_rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic [1:0]   idx,
  output logic         valid
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [2:0]     sum;

  // Rotating a doubled copy puts the pointer's request at bit 0.
  assign dbl = {req, req};
  assign rot = N'(dbl >> ptr);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    // Descending scan so the lowest rotated offset wins.
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        valid = 1'b1;
        sum   = {1'b0, ptr} + 3'(j);
        idx   = (sum >= 3'(N)) ? 2'(sum - 3'(N)) : sum[1:0];
      end
    end
  end

endmodule

// File: rtl/iecdrv_sd_arb.sv
// Arbitrates up to four drive-side SD sector requests onto one shared SD bridge.
// Grants are round-robin; a granted drive owns the bridge until its transfer releases.
module iecdrv_sd_arb
  import iecdrv_pkg::*;
#(
  parameter int NDR = 2
) (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic [31:0]    drv_lba      [NDR],
  input  logic [5:0]     drv_blk_cnt  [NDR],
  input  logic [NDR-1:0] drv_rd,
  input  logic [NDR-1:0] drv_wr,
  output logic [NDR-1:0] drv_ack,
  input  logic [7:0]     drv_buff_din [NDR],
  output logic [31:0]    sd_lba,
  output logic [5:0]     sd_blk_cnt,
  output logic           sd_rd,
  output logic           sd_wr,
  input  logic           sd_ack,
  output logic [7:0]     sd_buff_din,
  output logic           busy,
  output logic [1:0]     grant_idx
);

  localparam int N = iecdrv_clamp_ndr(NDR);

  arb_state_t     state_reg, state_next;
  logic [1:0]     rr_ptr_reg;
  logic [1:0]     grant_reg;
  logic           busy_reg;
  logic           sd_rd_reg;
  logic           sd_wr_reg;
  logic [NDR-1:0] drv_ack_reg;
  logic [31:0]    sd_lba_reg;
  logic [5:0]     sd_blk_cnt_reg;

  logic [N-1:0]   req_vec;
  logic [1:0]     pick_idx;
  logic           pick_valid;
  logic [31:0]    pick_lba;
  logic [5:0]     pick_blk;
  logic           pick_wr;
  logic           gnt_req;
  logic [NDR-1:0] ack_vec;
  logic [1:0]     rr_next;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_req
      assign req_vec[gi] = drv_rd[gi] | drv_wr[gi];
    end
  endgenerate

  iecdrv_rr_pick #(.N(N)) u_pick (
    .req   (req_vec),
    .ptr   (rr_ptr_reg),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Per-drive muxes for the candidate (pick) and the current owner (grant).
  always_comb begin
    pick_lba    = '0;
    pick_blk    = '0;
    pick_wr     = 1'b0;
    gnt_req     = 1'b0;
    sd_buff_din = '0;
    ack_vec     = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_idx == 2'(i)) begin
        pick_lba = drv_lba[i];
        pick_blk = drv_blk_cnt[i];
        pick_wr  = drv_wr[i];
      end
      if (grant_reg == 2'(i)) begin
        gnt_req     = drv_rd[i] | drv_wr[i];
        sd_buff_din = drv_buff_din[i];
        ack_vec[i]  = 1'b1;
      end
    end
  end

  assign rr_next = (grant_reg == 2'(N - 1)) ? 2'd0 : grant_reg + 2'd1;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (pick_valid) state_next = ST_REQ;
      ST_REQ: begin
        // An acknowledge in the same cycle as the drop still commits the transfer.
        if (sd_ack)       state_next = ST_XFER;
        else if (!gnt_req) state_next = ST_IDLE;
      end
      ST_XFER:    if (!sd_ack) state_next = ST_RELEASE;
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rr_ptr_reg     <= '0;
      grant_reg      <= '0;
      busy_reg       <= 1'b0;
      sd_rd_reg      <= 1'b0;
      sd_wr_reg      <= 1'b0;
      drv_ack_reg    <= '0;
      sd_lba_reg     <= '0;
      sd_blk_cnt_reg <= '0;
    end else begin
      busy_reg <= (state_next != ST_IDLE);
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_reg      <= pick_idx;
            sd_lba_reg     <= pick_lba;
            sd_blk_cnt_reg <= pick_blk;
            // Write wins when a drive raises both strobes.
            sd_wr_reg      <= pick_wr;
            sd_rd_reg      <= ~pick_wr;
          end
        end
        ST_REQ: begin
          if (sd_ack) begin
            sd_rd_reg   <= 1'b0;
            sd_wr_reg   <= 1'b0;
            drv_ack_reg <= ack_vec;
          end else if (!gnt_req) begin
            sd_rd_reg <= 1'b0;
            sd_wr_reg <= 1'b0;
          end
        end
        ST_XFER: begin
          if (!sd_ack) drv_ack_reg <= '0;
        end
        ST_RELEASE: rr_ptr_reg <= rr_next;
        default: ;
      endcase
    end
  end

  assign drv_ack    = drv_ack_reg;
  assign sd_lba     = sd_lba_reg;
  assign sd_blk_cnt = sd_blk_cnt_reg;
  assign sd_rd      = sd_rd_reg;
  assign sd_wr      = sd_wr_reg;
  assign busy       = busy_reg;
  assign grant_idx  = grant_reg;

endmodule

// File: tb/tb_iecdrv_sd_arb.sv
// Directed bench for iecdrv_sd_arb with two drive ports: a per-cycle vector table
// followed by hand-written reset-mid-transfer and write-priority sequences.
module tb_iecdrv_sd_arb;

  localparam logic [31:0] L0 = 32'h0000_0100;
  localparam logic [31:0] L1 = 32'h0000_0123;
  localparam logic [5:0]  B0 = 6'd3;
  localparam logic [5:0]  B1 = 6'd7;
  localparam logic [31:0] LZ = 32'h0;
  localparam logic [5:0]  BZ = 6'd0;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [31:0] drv_lba      [2];
  logic [5:0]  drv_blk_cnt  [2];
  logic [1:0]  drv_rd;
  logic [1:0]  drv_wr;
  logic [1:0]  drv_ack;
  logic [7:0]  drv_buff_din [2];
  logic [31:0] sd_lba;
  logic [5:0]  sd_blk_cnt;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_din;
  logic        busy;
  logic [1:0]  grant_idx;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic        rst;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic        ack;
    logic [44:0] exp;
  } vec_t;

  vec_t vecs[$];

  iecdrv_sd_arb #(.NDR(2)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .drv_lba      (drv_lba),
    .drv_blk_cnt  (drv_blk_cnt),
    .drv_rd       (drv_rd),
    .drv_wr       (drv_wr),
    .drv_ack      (drv_ack),
    .drv_buff_din (drv_buff_din),
    .sd_lba       (sd_lba),
    .sd_blk_cnt   (sd_blk_cnt),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_din  (sd_buff_din),
    .busy         (busy),
    .grant_idx    (grant_idx)
  );

  always #5 clk_sys = ~clk_sys;

  // {busy, sd_rd, sd_wr, drv_ack, grant_idx, sd_lba, sd_blk_cnt}
  function automatic logic [44:0] pk(input logic b, input logic r, input logic w,
                                     input logic [1:0] a, input logic [1:0] g,
                                     input logic [31:0] l, input logic [5:0] k);
    return {b, r, w, a, g, l, k};
  endfunction

  function automatic logic [44:0] obs();
    return {busy, sd_rd, sd_wr, drv_ack, grant_idx, sd_lba, sd_blk_cnt};
  endfunction

  task automatic add(input logic rst, input logic [1:0] rd, input logic [1:0] wr,
                     input logic ack, input logic [44:0] exp);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.ack = ack; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [44:0] act, input logic [44:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("[TB] %s ok (%h)", nm, act);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    drv_rd          = '0;
    drv_wr          = '0;
    sd_ack          = 1'b0;
    drv_lba[0]      = L0;
    drv_lba[1]      = L1;
    drv_blk_cnt[0]  = B0;
    drv_blk_cnt[1]  = B1;
    drv_buff_din[0] = 8'h3C;
    drv_buff_din[1] = 8'h11;

    // Reset, then drive 1 read with a 5-cycle acknowledge.
    add(1, 2'b00, 2'b00, 0, pk(0, 0, 0, 2'b00, 2'd0, LZ, BZ));
    add(0, 2'b10, 2'b00, 0, pk(1, 1, 0, 2'b00, 2'd1, L1, B1));
    add(0, 2'b10, 2'b00, 0, pk(1, 1, 0, 2'b00, 2'd1, L1, B1));
    for (int i = 0; i < 5; i++)
      add(0, 2'b10, 2'b00, 1, pk(1, 0, 0, 2'b10, 2'd1, L1, B1));
    add(0, 2'b00, 2'b00, 0, pk(1, 0, 0, 2'b00, 2'd1, L1, B1));
    add(0, 2'b00, 2'b00, 0, pk(0, 0, 0, 2'b00, 2'd1, L1, B1));
    // Simultaneous requests: pointer back at 0, so drive 0 then drive 1.
    add(0, 2'b11, 2'b00, 0, pk(1, 1, 0, 2'b00, 2'd0, L0, B0));
    add(0, 2'b11, 2'b00, 1, pk(1, 0, 0, 2'b01, 2'd0, L0, B0));
    add(0, 2'b11, 2'b00, 0, pk(1, 0, 0, 2'b00, 2'd0, L0, B0));
    add(0, 2'b11, 2'b00, 0, pk(0, 0, 0, 2'b00, 2'd0, L0, B0));
    add(0, 2'b11, 2'b00, 0, pk(1, 1, 0, 2'b00, 2'd1, L1, B1));
    add(0, 2'b11, 2'b00, 1, pk(1, 0, 0, 2'b10, 2'd1, L1, B1));
    add(0, 2'b11, 2'b00, 0, pk(1, 0, 0, 2'b00, 2'd1, L1, B1));
    // Drive 0 reads continuously, drive 1 write pending: grants 0,1,0.
    add(0, 2'b01, 2'b10, 0, pk(0, 0, 0, 2'b00, 2'd1, L1, B1));
    add(0, 2'b01, 2'b10, 0, pk(1, 1, 0, 2'b00, 2'd0, L0, B0));
    add(0, 2'b01, 2'b10, 1, pk(1, 0, 0, 2'b01, 2'd0, L0, B0));
    add(0, 2'b01, 2'b10, 0, pk(1, 0, 0, 2'b00, 2'd0, L0, B0));
    add(0, 2'b01, 2'b10, 0, pk(0, 0, 0, 2'b00, 2'd0, L0, B0));
    add(0, 2'b01, 2'b10, 0, pk(1, 0, 1, 2'b00, 2'd1, L1, B1));
    add(0, 2'b01, 2'b10, 1, pk(1, 0, 0, 2'b10, 2'd1, L1, B1));
    add(0, 2'b01, 2'b10, 0, pk(1, 0, 0, 2'b00, 2'd1, L1, B1));
    add(0, 2'b01, 2'b10, 0, pk(0, 0, 0, 2'b00, 2'd1, L1, B1));
    add(0, 2'b01, 2'b10, 0, pk(1, 1, 0, 2'b00, 2'd0, L0, B0));
    // Drive 0 drops its read in REQ: abort with no ack, busy low next cycle.
    add(0, 2'b00, 2'b10, 0, pk(0, 0, 0, 2'b00, 2'd0, L0, B0));
    add(0, 2'b00, 2'b00, 0, pk(0, 0, 0, 2'b00, 2'd0, L0, B0));
    // Abort left the pointer at 0: both request, drive 0 wins; then abort again.
    add(0, 2'b11, 2'b00, 0, pk(1, 1, 0, 2'b00, 2'd0, L0, B0));
    add(0, 2'b00, 2'b00, 0, pk(0, 0, 0, 2'b00, 2'd0, L0, B0));
    // sd_ack while idle is ignored.
    add(0, 2'b00, 2'b00, 1, pk(0, 0, 0, 2'b00, 2'd0, L0, B0));

    foreach (vecs[i]) begin
      reset  = vecs[i].rst;
      drv_rd = vecs[i].rd;
      drv_wr = vecs[i].wr;
      sd_ack = vecs[i].ack;
      step();
      chk($sformatf("row%0d", i), obs(), vecs[i].exp);
    end

    // Reset in the middle of a transfer, then a late sd_ack.
    sd_ack = 1'b0; drv_rd = 2'b10; drv_wr = 2'b00;
    step(); chk("h1_req", obs(), pk(1, 1, 0, 2'b00, 2'd1, L1, B1));
    sd_ack = 1'b1;
    step(); chk("h1_xfer", obs(), pk(1, 0, 0, 2'b10, 2'd1, L1, B1));
    reset = 1'b1; drv_rd = 2'b00;
    step(); chk("h1_reset", obs(), pk(0, 0, 0, 2'b00, 2'd0, LZ, BZ));
    reset = 1'b0;
    step(); chk("h1_late_ack", obs(), pk(0, 0, 0, 2'b00, 2'd0, LZ, BZ));
    sd_ack = 1'b0;
    step(); chk("h1_idle", obs(), pk(0, 0, 0, 2'b00, 2'd0, LZ, BZ));

    // Drive 1 raises rd and wr together: write wins; write data follows drive 1.
    drv_buff_din[1] = 8'hA5;
    drv_rd = 2'b10; drv_wr = 2'b10;
    step(); chk("h2_dir", obs(), pk(1, 0, 1, 2'b00, 2'd1, L1, B1));
    chk("h2_din_a5", {37'b0, sd_buff_din}, {37'b0, 8'hA5});
    drv_buff_din[1] = 8'h5A; drv_buff_din[0] = 8'hFF;
    #1 chk("h2_din_5a", {37'b0, sd_buff_din}, {37'b0, 8'h5A});
    // A new request on drive 0 while drive 1 owns the bridge changes nothing.
    drv_rd = 2'b11; sd_ack = 1'b1;
    step(); chk("h2_xfer", obs(), pk(1, 0, 0, 2'b10, 2'd1, L1, B1));
    drv_rd = 2'b00; drv_wr = 2'b00; sd_ack = 1'b0;
    step(); chk("h2_release", obs(), pk(1, 0, 0, 2'b00, 2'd1, L1, B1));
    step(); chk("h2_idle", obs(), pk(0, 0, 0, 2'b00, 2'd1, L1, B1));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
